// File: rtl/mem_fill_responder.sv
// -----------------------------------------------------------------------------
// mem_fill_responder
//
// Main-memory responder behind the cache arbiter. It is a pipelined word memory
// with a fixed read latency. It accepts one request per cycle and applies no
// back-pressure.
//   - Writes commit to the array at the request edge and produce no response.
//   - Reads travel down a (valid, address) shift pipeline. The array is sampled
//     as the read leaves the last stage, so a write that lands while the read is
//     in flight is seen by that read.
//   - data_valid rises exactly LATENCY cycles after the request cycle.
//
// Parameters
//   ADDR_W   word-index width; the array holds 2**ADDR_W 16-bit words (<= 15)
//   LATENCY  read latency in cycles, request cycle to data_valid (1..8)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (clears the pipeline and outputs;
//               array contents persist)
//   enable      request valid this cycle
//   wr          1 = write, 0 = read (qualified by enable)
//   addr        byte address; bit 0 ignored; word index = addr[ADDR_W:1]
//   data_in     write data
//   data_out    read data, held between responses
//   data_valid  read response valid this cycle
//   data_addr   byte address of the returned read, bit 0 forced to 0
//   busy        at least one read in flight, including its returning cycle
//   rd_count    accepted reads, saturating (only with MEM_STATS_EN)
//   wr_count    accepted writes, saturating (only with MEM_STATS_EN)
//
// Optional feature: define MEM_STATS_EN to add the rd_count/wr_count outputs.
// -----------------------------------------------------------------------------
module mem_fill_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [15:0] data_addr,
  output logic        busy
`ifdef MEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic rd_req;
  logic wr_req;
  assign rd_req = enable & ~wr;
  assign wr_req = enable &  wr;

  // Bit 0 of the byte address carries no information for a word memory.
  logic unused_addr_bit0;
  assign unused_addr_bit0 = addr[0];

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [15:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch; clearing it would prevent RAM
  // inference, and committed writes must survive a reset anyway.
  always_ff @(posedge clk) begin
    if (!rst && wr_req) begin
      mem_q[addr[ADDR_W:1]] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline. The last_* signals describe the read that samples the array
  // on this edge; the output register adds the final cycle of latency.
  // ---------------------------------------------------------------------------
  logic        last_v;
  logic [14:0] last_a;
  logic        pipe_busy;

  if (LATENCY == 1) begin : g_direct
    assign last_v    = rd_req;
    assign last_a    = addr[15:1];
    assign pipe_busy = 1'b0;
  end else begin : g_pipe
    logic [LATENCY-2:0] pv_q;
    logic [14:0]        pa_q [LATENCY-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        pv_q <= '0;
      end else begin
        // NOTE: non-blocking assignments let each stage take its neighbour's
        // old value, so the loop order does not matter.
        pv_q[0] <= rd_req;
        for (int i = 1; i < LATENCY - 1; i++) begin
          pv_q[i] <= pv_q[i-1];
        end
      end
    end

    // Address stages carry no reset; they are only meaningful beside a set
    // valid bit.
    always_ff @(posedge clk) begin
      pa_q[0] <= addr[15:1];
      for (int i = 1; i < LATENCY - 1; i++) begin
        pa_q[i] <= pa_q[i-1];
      end
    end

    assign last_v    = pv_q[LATENCY-2];
    assign last_a    = pa_q[LATENCY-2];
    assign pipe_busy = |pv_q;
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic        data_valid_q, data_valid_d;
  logic [15:0] data_out_q,   data_out_d;
  logic [15:0] data_addr_q,  data_addr_d;

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    data_valid_d = last_v;
    data_out_d   = data_out_q;
    data_addr_d  = data_addr_q;
    if (last_v) begin
      // A write on this same edge is not yet visible here: the read gets the
      // old word.
      data_out_d  = mem_q[last_a[ADDR_W-1:0]];
      data_addr_d = {last_a, 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
      data_addr_q  <= '0;
    end else begin
      data_valid_q <= data_valid_d;
      data_out_q   <= data_out_d;
      data_addr_q  <= data_addr_d;
    end
  end

  assign data_valid = data_valid_q;
  assign data_out   = data_out_q;
  assign data_addr  = data_addr_q;
  assign busy       = pipe_busy | data_valid_q;

  // ---------------------------------------------------------------------------
  // Optional request statistics
  // ---------------------------------------------------------------------------
`ifdef MEM_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (rd_req && (rd_count_q != 16'hFFFF)) rd_count_d = rd_count_q + 16'd1;
    if (wr_req && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mem_fill_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_fill_responder
//
// Self-checking bench for mem_fill_responder (ADDR_W=10, LATENCY=4).
// Every table row is one clock cycle: the inputs driven in that cycle and the
// outputs expected in that same cycle. Inputs are driven and outputs sampled
// on the falling edge. Hand-written sequences cover reset behaviour,
// persistence across reset and the optional MEM_STATS_EN counters.
// -----------------------------------------------------------------------------
module tb_mem_fill_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic [15:0] data_addr;
  logic        busy;
`ifdef MEM_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  always #5 clk = ~clk;

  mem_fill_responder #(.ADDR_W(10), .LATENCY(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_addr  (data_addr),
    .busy       (busy)
`ifdef MEM_STATS_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        en;
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
    logic        ev;  // expected data_valid
    logic        eb;  // expected busy
    logic [15:0] eo;  // expected data_out (held value when not valid)
    logic [15:0] ea;  // expected data_addr
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d,
                     input logic ev, input logic eb, input logic [15:0] eo, input logic [15:0] ea);
    vec_t v;
    v.en = en; v.wr = w; v.a = a; v.d = d;
    v.ev = ev; v.eb = eb; v.eo = eo; v.ea = ea;
    tbl.push_back(v);
  endtask

  // One cycle: sample outputs, then drive this cycle's inputs, on the falling edge.
  task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic eb,
                            input logic [15:0] eo, input logic [15:0] ea);
    check({tag, ".data_valid"}, {15'd0, data_valid}, {15'd0, ev});
    check({tag, ".busy"},       {15'd0, busy},       {15'd0, eb});
    check({tag, ".data_out"},   data_out,            eo);
    check({tag, ".data_addr"},  data_addr,           ea);
  endtask

  initial begin
    // ---- stimulus table (row index = cycle number) ----
    // write 0x1234 @0x0010, read back one cycle later
    add(1, 1, 16'h0010, 16'h1234, 0, 0, 16'h0000, 16'h0000);        // t0
    add(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000);        // t1
    for (int i = 0; i < 3; i++)
      add(0, 0, 16'h0, 16'h0, 0, 1, 16'h0000, 16'h0000);            // t2-t4
    add(0, 0, 16'h0, 16'h0, 1, 1, 16'h1234, 16'h0010);              // t5
    add(0, 0, 16'h0, 16'h0, 0, 0, 16'h1234, 16'h0010);              // t6
    // preload burst words with their index
    for (int i = 0; i < 8; i++)
      add(1, 1, 16'(16'h0040 + 2 * i), 16'(i), 0, 0, 16'h1234, 16'h0010); // t7-t14
    // 8-read burst, returns on burst cycles 4..11
    add(1, 0, 16'h0040, 16'h0, 0, 0, 16'h1234, 16'h0010);           // t15
    for (int i = 1; i < 4; i++)
      add(1, 0, 16'(16'h0040 + 2 * i), 16'h0, 0, 1, 16'h1234, 16'h0010); // t16-t18
    for (int i = 4; i < 8; i++)
      add(1, 0, 16'(16'h0040 + 2 * i), 16'h0, 1, 1, 16'(i - 4), 16'(16'h0040 + 2 * (i - 4))); // t19-t22
    for (int k = 4; k < 8; k++)
      add(0, 0, 16'h0, 16'h0, 1, 1, 16'(k), 16'(16'h0040 + 2 * k)); // t23-t26
    add(0, 0, 16'h0, 16'h0, 0, 0, 16'h0007, 16'h004E);              // t27 busy dropped
    // write to a word while an older read of it is in flight
    add(1, 1, 16'h0020, 16'hAAAA, 0, 0, 16'h0007, 16'h004E);        // t28
    add(1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0007, 16'h004E);        // t29 read
    add(0, 0, 16'h0, 16'h0, 0, 1, 16'h0007, 16'h004E);              // t30
    add(1, 1, 16'h0020, 16'h5555, 0, 1, 16'h0007, 16'h004E);        // t31 write, 2 after
    add(0, 0, 16'h0, 16'h0, 0, 1, 16'h0007, 16'h004E);              // t32
    add(0, 0, 16'h0, 16'h0, 1, 1, 16'h5555, 16'h0020);              // t33 sees new data
    add(0, 0, 16'h0, 16'h0, 0, 0, 16'h5555, 16'h0020);              // t34
    // write on the same edge the read samples the array -> old value
    add(1, 0, 16'h0020, 16'h0000, 0, 0, 16'h5555, 16'h0020);        // t35 read
    add(0, 0, 16'h0, 16'h0, 0, 1, 16'h5555, 16'h0020);              // t36
    add(0, 0, 16'h0, 16'h0, 0, 1, 16'h5555, 16'h0020);              // t37
    add(1, 1, 16'h0020, 16'h6666, 0, 1, 16'h5555, 16'h0020);        // t38 write
    add(0, 0, 16'h0, 16'h0, 1, 1, 16'h5555, 16'h0020);              // t39 old value
    add(1, 0, 16'h0020, 16'h0000, 0, 0, 16'h5555, 16'h0020);        // t40 read again
    for (int i = 0; i < 3; i++)
      add(0, 0, 16'h0, 16'h0, 0, 1, 16'h5555, 16'h0020);            // t41-t43
    add(0, 0, 16'h0, 16'h0, 1, 1, 16'h6666, 16'h0020);              // t44 new value
    add(0, 0, 16'h0, 16'h0, 0, 0, 16'h6666, 16'h0020);              // t45
    // address wrap: 0x0802 and 0x0803 alias word 1 (addr 0x0002)
    add(1, 1, 16'h0802, 16'hBEEF, 0, 0, 16'h6666, 16'h0020);        // t46
    add(1, 0, 16'h0002, 16'h0000, 0, 0, 16'h6666, 16'h0020);        // t47
    for (int i = 0; i < 3; i++)
      add(0, 0, 16'h0, 16'h0, 0, 1, 16'h6666, 16'h0020);            // t48-t50
    add(0, 0, 16'h0, 16'h0, 1, 1, 16'hBEEF, 16'h0002);              // t51
    add(1, 0, 16'h0803, 16'h0000, 0, 0, 16'hBEEF, 16'h0002);        // t52 odd byte addr
    for (int i = 0; i < 3; i++)
      add(0, 0, 16'h0, 16'h0, 0, 1, 16'hBEEF, 16'h0002);            // t53-t55
    add(0, 0, 16'h0, 16'h0, 1, 1, 16'hBEEF, 16'h0802);              // t56 bit 0 cleared
    add(0, 0, 16'h0, 16'h0, 0, 0, 16'hBEEF, 16'h0802);              // t57

    // ---- reset and idle ----
    rst = 1'b1;
    drive(0, 0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_outs("idle", 0, 0, 16'h0000, 16'h0000);
    end

    // ---- table ----
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      check_outs($sformatf("t%0d", i), tbl[i].ev, tbl[i].eb, tbl[i].eo, tbl[i].ea);
      drive(tbl[i].en, tbl[i].wr, tbl[i].a, tbl[i].d);
    end

    // ---- reset with reads in flight, stats ----
    @(negedge clk);
    drive(0, 0, 16'h0, 16'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef MEM_STATS_EN
    check("stats.rd_after_rst", rd_count, 16'd0);
    check("stats.wr_after_rst", wr_count, 16'd0);
`endif
    drive(1, 1, 16'h0100, 16'hC0DE); @(negedge clk);
    drive(1, 1, 16'h0102, 16'hF00D); @(negedge clk);
    drive(1, 0, 16'h0100, 16'h0000); @(negedge clk);
    drive(1, 0, 16'h0102, 16'h0000); @(negedge clk);
    drive(1, 0, 16'h0010, 16'h0000); @(negedge clk);
    drive(0, 0, 16'h0, 16'h0);
    check("flight.busy", {15'd0, busy}, 16'd1);
`ifdef MEM_STATS_EN
    check("stats.rd_count", rd_count, 16'd3);
    check("stats.wr_count", wr_count, 16'd2);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef MEM_STATS_EN
    check("stats.rd_cleared", rd_count, 16'd0);
    check("stats.wr_cleared", wr_count, 16'd0);
`endif
    for (int i = 0; i < 8; i++) begin
      check_outs("post_rst", 0, 0, 16'h0000, 16'h0000);
      @(negedge clk);
    end

    // ---- writes committed before reset persist ----
    drive(1, 0, 16'h0100, 16'h0000); @(negedge clk);
    drive(1, 0, 16'h0010, 16'h0000); @(negedge clk);
    drive(0, 0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    check_outs("persist0", 1, 1, 16'hC0DE, 16'h0100);
    @(negedge clk);
    check_outs("persist1", 1, 1, 16'h1234, 16'h0010);
    @(negedge clk);
    check_outs("persist_end", 0, 0, 16'h1234, 16'h0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
